// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ==========================================================================
// pipeline_hazard_ctrl: destination-tag scoreboard driving stalls, operand
// forwarding, WB bypass, branch-redirect flush and halt drain.  Rev 1.0
// ==========================================================================
module pipeline_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int REG_W      = 5,
  parameter int FWD_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_ecall_halt_i,
  input  logic             ex_redirect_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             flush_if_id_o,
  output logic             id_ex_bubble_o,
  output logic [FWD_W-1:0] fwd_rs1_sel_o,
  output logic [FWD_W-1:0] fwd_rs2_sel_o,
  output logic             id_rs1_bypass_o,
  output logic             id_rs2_bypass_o,
  output logic             halted_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] tag_valid_q;
  logic [DEPTH-1:0] tag_load_q;
  logic [REG_W-1:0] tag_rd_q [DEPTH];

  logic [REG_W-1:0] ex_rs1_q, ex_rs2_q;
  logic             ex_uses1_q, ex_uses2_q;

  logic stall;
  logic bubble;
  logic halt_accept;

  // Load-use: a load whose result is not yet forwardable feeds a used ID source.
  always_comb begin
    stall = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      if ((j + 1 < LOAD_READY) && tag_valid_q[j] && tag_load_q[j] &&
          (tag_rd_q[j] != '0) &&
          ((id_uses_rs1_i && (tag_rd_q[j] == id_rs1_i)) ||
           (id_uses_rs2_i && (tag_rd_q[j] == id_rs2_i)))) begin
        stall = 1'b1;
      end
    end
    stall = stall & id_valid_i;
  end

  // Walk from the oldest stage down so the youngest matching producer wins.
  always_comb begin
    fwd_rs1_sel_o = '0;
    fwd_rs2_sel_o = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (!reset && tag_valid_q[k] && (tag_rd_q[k] != '0)) begin
        if (ex_uses1_q && (tag_rd_q[k] == ex_rs1_q)) fwd_rs1_sel_o = FWD_W'(k);
        if (ex_uses2_q && (tag_rd_q[k] == ex_rs2_q)) fwd_rs2_sel_o = FWD_W'(k);
      end
    end
  end

  always_comb begin
    id_rs1_bypass_o = 1'b0;
    id_rs2_bypass_o = 1'b0;
    if (!reset && tag_valid_q[DEPTH-1]) begin
      id_rs1_bypass_o = (id_rs1_i != '0) && (tag_rd_q[DEPTH-1] == id_rs1_i);
      id_rs2_bypass_o = (id_rs2_i != '0) && (tag_rd_q[DEPTH-1] == id_rs2_i);
    end
  end

  assign halt_accept = !reset && (state_q == ST_RUN) && id_valid_i &&
                       id_ecall_halt_i && !stall && !ex_redirect_i;

  // Pipeline control; DRAIN and HALTED keep the frozen defaults.
  always_comb begin
    pc_write_o    = 1'b0;
    if_id_write_o = 1'b0;
    flush_if_id_o = 1'b0;
    bubble        = 1'b1;
    halted_o      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect_i) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            flush_if_id_o = 1'b1;
            bubble        = 1'b1;
          end else begin
            pc_write_o    = !stall;
            if_id_write_o = !stall;
            bubble        = stall;
          end
        end
        ST_HALTED: halted_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign id_ex_bubble_o = bubble;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_accept) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DEPTH);
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accepted ecall travels on as an invalid tag so nothing forwards from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= '0;
      tag_load_q  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_rd_q[k] <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_uses1_q  <= 1'b0;
      ex_uses2_q  <= 1'b0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_load_q[k]  <= tag_load_q[k-1];
        tag_rd_q[k]    <= tag_rd_q[k-1];
      end
      tag_valid_q[0] <= id_valid_i & id_reg_write_i & ~bubble & ~halt_accept;
      tag_load_q[0]  <= id_mem_read_i;
      tag_rd_q[0]    <= id_rd_i;
      if (bubble) begin
        ex_rs1_q   <= '0;
        ex_rs2_q   <= '0;
        ex_uses1_q <= 1'b0;
        ex_uses2_q <= 1'b0;
      end else begin
        ex_rs1_q   <= id_rs1_i;
        ex_rs2_q   <= id_rs2_i;
        ex_uses1_q <= id_valid_i & id_uses_rs1_i;
        ex_uses2_q <= id_valid_i & id_uses_rs2_i;
      end
    end
  end

endmodule
`default_nettype wire
